// File: rtl/life_engine.sv
// rtl/life_engine.sv - double-banked Game of Life cell store and B3/S23 generation engine
module life_engine #(
    parameter int WIDTH     = 4,
    parameter int P_PARAM_N = 8,
    parameter int P_PARAM_M = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*WIDTH-1:0]   rd_addr,
    output logic                 rd_live,
    input  logic                 step,
    input  logic                 clear,
    input  logic                 set_valid,
    input  logic [2*WIDTH-1:0]   set_pos,
    input  logic                 set_value,
    output logic                 set_ready,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          gen_count
);
    localparam int AW = 2 * WIDTH;
    localparam int NM = P_PARAM_N * P_PARAM_M;
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int CW = (P_PARAM_N > 1) ? $clog2(P_PARAM_N) : 1;
    localparam int RW = (P_PARAM_M > 1) ? $clog2(P_PARAM_M) : 1;
    localparam logic [AW-1:0] CELLS  = AW'(NM);
    localparam logic [IW-1:0] LAST   = IW'(NM - 1);
    localparam logic [CW-1:0] X_LAST = CW'(P_PARAM_N - 1);
    localparam logic [RW-1:0] Y_LAST = RW'(P_PARAM_M - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SWAP, S_CLEAR} state_t;

    state_t          state, state_next;
    logic [NM-1:0]   bank0, bank1, front, back, rd_bank;
    logic            sel;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cx, xm, xp;
    logic [RW-1:0]   cy, ym, yp;
    logic            at_last, walking;
    logic [3:0]      nbr;
    logic            next_bit, rd_bit;
    logic            wr_en, wr_bank, wr_data;
    logic [IW-1:0]   wr_addr;

    function automatic logic cell_at(input logic [NM-1:0] b, input logic [CW-1:0] x,
                                     input logic [RW-1:0] y);
        logic [IW-1:0] a;
        a = IW'(y) * IW'(P_PARAM_N) + IW'(x);
        return b[a];
    endfunction

    assign front   = sel ? bank1 : bank0;
    assign back    = sel ? bank0 : bank1;
    assign at_last = (idx == LAST);
    assign walking = (state == S_CALC) || (state == S_CLEAR);

    // Toroidal neighbourhood of the cell at (cx, cy)
    assign xm = (cx == '0)     ? X_LAST : cx - CW'(1);
    assign xp = (cx == X_LAST) ? '0     : cx + CW'(1);
    assign ym = (cy == '0)     ? Y_LAST : cy - RW'(1);
    assign yp = (cy == Y_LAST) ? '0     : cy + RW'(1);

    assign nbr = {3'b0, cell_at(front, xm, ym)} + {3'b0, cell_at(front, cx, ym)}
               + {3'b0, cell_at(front, xp, ym)} + {3'b0, cell_at(front, xm, cy)}
               + {3'b0, cell_at(front, xp, cy)} + {3'b0, cell_at(front, xm, yp)}
               + {3'b0, cell_at(front, cx, yp)} + {3'b0, cell_at(front, xp, yp)};
    assign next_bit = (nbr == 4'd3) || (cell_at(front, cx, cy) && (nbr == 4'd2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (clear) state_next = S_CLEAR;
                     else if (step) state_next = S_CALC;
            S_CALC:  if (at_last) state_next = S_SWAP;
            S_SWAP:  state_next = S_IDLE;
            S_CLEAR: if (at_last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        set_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        done      = (state == S_SWAP) || ((state == S_CLEAR) && at_last);
    end

    // Single bank write port: manual edit, generation write-back, or clear
    always_comb begin
        wr_en   = 1'b0;
        wr_bank = sel;
        wr_addr = idx;
        wr_data = 1'b0;
        case (state)
            S_IDLE: if (!clear && !step && set_valid && (set_pos < CELLS)) begin
                wr_en   = 1'b1;
                wr_addr = set_pos[IW-1:0];
                wr_data = set_value;
            end
            S_CALC: begin
                wr_en   = 1'b1;
                wr_bank = ~sel;
                wr_data = next_bit;
            end
            S_CLEAR: wr_en = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank0 <= '0;
            bank1 <= '0;
        end else if (wr_en) begin
            if (wr_bank) bank1[wr_addr] <= wr_data;
            else         bank0[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            cx  <= '0;
            cy  <= '0;
        end else if (walking && !at_last) begin
            idx <= idx + IW'(1);
            if (cx == X_LAST) begin
                cx <= '0;
                cy <= cy + RW'(1);
            end else begin
                cx <= cx + CW'(1);
            end
        end else begin
            idx <= '0;
            cx  <= '0;
            cy  <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel       <= 1'b0;
            gen_count <= '0;
        end else if (state == S_SWAP) begin
            sel       <= ~sel;
            gen_count <= gen_count + 16'd1;
        end else if ((state == S_CLEAR) && at_last) begin
            gen_count <= '0;
        end
    end

    // SWAP reads the completed back bank and the final CLEAR cycle reads zero,
    // so scanout sees the new board one edge before the bank/select update lands.
    assign rd_bank = (state == S_SWAP) ? back : front;
    assign rd_bit  = (rd_addr < CELLS) && rd_bank[rd_addr[IW-1:0]]
                     && !((state == S_CLEAR) && at_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_live <= 1'b0;
        else        rd_live <= rd_bit;
    end
endmodule

// File: tb/tb_life_engine.sv
// tb/tb_life_engine.sv - randomized self-checking bench for life_engine against a board model
module tb_life_engine;
    localparam int N  = 8;
    localparam int M  = 8;
    localparam int NM = N * M;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic        rd_live;
    logic        step = 1'b0, clear = 1'b0, set_valid = 1'b0, set_value = 1'b0;
    logic [7:0]  set_pos = '0;
    logic        set_ready, busy, done;
    logic [15:0] gen_count;

    int total = 0;
    int bad   = 0;

    logic [63:0] model, board, expv;
    int          gen_exp;
    int          bc, dc, mb, nsteps;
    logic        inj_ready;

    life_engine #(.WIDTH(4), .P_PARAM_N(N), .P_PARAM_M(M)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_live(rd_live),
        .step(step), .clear(clear), .set_valid(set_valid), .set_pos(set_pos),
        .set_value(set_value), .set_ready(set_ready), .busy(busy), .done(done),
        .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] life_next(input logic [63:0] b);
        logic [63:0] r;
        r = '0;
        for (int y = 0; y < M; y++) begin
            for (int x = 0; x < N; x++) begin
                int n;
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (dx != 0 || dy != 0)
                            n += int'(b[((y + dy + M) % M) * N + (x + dx + N) % N]);
                r[y*N+x] = (n == 3) || (b[y*N+x] && n == 2);
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] shift_diag(input logic [63:0] b);
        logic [63:0] r;
        r = '0;
        for (int y = 0; y < M; y++)
            for (int x = 0; x < N; x++)
                if (b[y*N+x]) r[((y + 1) % M) * N + (x + 1) % N] = 1'b1;
        return r;
    endfunction

    task automatic write_cell(input int pos, input logic val);
        @(negedge clk);
        set_valid = 1'b1; set_pos = 8'(pos); set_value = val;
        @(negedge clk);
        set_valid = 1'b0;
    endtask

    task automatic read_board(output logic [63:0] v);
        for (int a = 0; a < NM; a++) begin
            @(negedge clk);
            rd_addr = 8'(a);
            @(negedge clk);
            v[a] = rd_live;
        end
    endtask

    task automatic do_step(input bit inject, input bit mon, input logic mon_val,
                           output int busy_c, output int done_c, output int mon_bad,
                           output logic ready_seen);
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        busy_c = 0; done_c = 0; mon_bad = 0; ready_seen = 1'bx;
        while (busy === 1'b1 && busy_c < 1000) begin
            if (done === 1'b1) done_c++;
            if (mon && rd_live !== mon_val) mon_bad++;
            if (inject && busy_c == 10) begin
                step = 1'b1; set_valid = 1'b1; set_pos = 8'd0; set_value = 1'b1;
                ready_seen = set_ready;
            end else begin
                step = 1'b0; set_valid = 1'b0;
            end
            busy_c++;
            @(negedge clk);
        end
        step = 1'b0; set_valid = 1'b0;
    endtask

    task automatic do_clear(input bit with_step, output int busy_c, output int done_c);
        @(negedge clk); clear = 1'b1; step = with_step;
        @(negedge clk); clear = 1'b0; step = 1'b0;
        busy_c = 0; done_c = 0;
        while (busy === 1'b1 && busy_c < 1000) begin
            if (done === 1'b1) done_c++;
            busy_c++;
            @(negedge clk);
        end
    endtask

    initial begin
        gen_exp = 0;
        model   = '0;
        #12 rst_n = 1'b1;
        @(negedge clk);
        check("reset_outputs", {59'd0, rd_live, set_ready, busy, done, 1'b0},
              {59'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        check("reset_gen", 64'(gen_count), 64'd0);

        // Blinker, two generations
        write_cell(2*N+3, 1'b1); write_cell(3*N+3, 1'b1); write_cell(4*N+3, 1'b1);
        model = 64'(1) << (2*N+3) | 64'(1) << (3*N+3) | 64'(1) << (4*N+3);
        do_step(1'b0, 1'b0, 1'b0, bc, dc, mb, inj_ready);
        check("blinker_busy", 64'(bc), 64'(NM + 1));
        check("blinker_done", 64'(dc), 64'd1);
        read_board(board);
        expv = 64'(1) << (3*N+2) | 64'(1) << (3*N+3) | 64'(1) << (3*N+4);
        check("blinker_h", board, expv);
        check("blinker_model", board, life_next(model));
        check("blinker_gen1", 64'(gen_count), 64'd1);
        do_step(1'b0, 1'b0, 1'b0, bc, dc, mb, inj_ready);
        read_board(board);
        check("blinker_v", board, model);
        check("blinker_gen2", 64'(gen_count), 64'd2);

        // Toroidal glider from the bottom-right corner
        do_clear(1'b0, bc, dc);
        check("clear_busy", 64'(bc), 64'(NM));
        check("clear_gen", 64'(gen_count), 64'd0);
        model = '0;
        foreach (model[i]) ;
        model[5*N+6] = 1'b1; model[6*N+7] = 1'b1; model[7*N+5] = 1'b1;
        model[7*N+6] = 1'b1; model[7*N+7] = 1'b1;
        for (int i = 0; i < NM; i++) if (model[i]) write_cell(i, 1'b1);
        for (int k = 0; k < 4; k++) do_step(1'b0, 1'b0, 1'b0, bc, dc, mb, inj_ready);
        read_board(board);
        check("glider_shift", board, shift_diag(model));
        check("glider_pop", 64'($countones(board)), 64'd5);
        check("glider_gen", 64'(gen_count), 64'd4);

        // Still-life block: scanout stays stable, busy rejection, out-of-range read
        do_clear(1'b0, bc, dc);
        write_cell(1*N+1, 1'b1); write_cell(1*N+2, 1'b1);
        write_cell(2*N+1, 1'b1); write_cell(2*N+2, 1'b1);
        @(negedge clk); rd_addr = 8'(1*N+1);
        do_step(1'b0, 1'b1, 1'b1, bc, dc, mb, inj_ready);
        check("block_stable_live", 64'(mb), 64'd0);
        @(negedge clk); rd_addr = 8'd0;
        do_step(1'b1, 1'b1, 1'b0, bc, dc, mb, inj_ready);
        check("reject_ready", 64'(inj_ready), 64'd0);
        check("reject_busy", 64'(bc), 64'(NM + 1));
        check("block_stable_dead", 64'(mb), 64'd0);
        repeat (3) @(negedge clk);
        check("reject_no_requeue", 64'(busy), 64'd0);
        read_board(board);
        check("reject_board", board, 64'h0000_0000_0006_0600);
        check("reject_gen", 64'(gen_count), 64'd2);
        @(negedge clk); rd_addr = 8'(NM);
        @(negedge clk);
        check("rd_out_of_range", 64'(rd_live), 64'd0);

        // Clear wins over a simultaneous step
        for (int i = 0; i < NM; i++) write_cell(i, 1'b1);
        write_cell(NM + 3, 1'b0);
        read_board(board);
        check("fill_board", board, {64{1'b1}});
        do_clear(1'b1, bc, dc);
        check("clrprio_busy", 64'(bc), 64'(NM));
        check("clrprio_done", 64'(dc), 64'd1);
        repeat (3) @(negedge clk);
        check("clrprio_no_calc", 64'(busy), 64'd0);
        read_board(board);
        check("clrprio_board", board, 64'd0);
        check("clrprio_gen", 64'(gen_count), 64'd0);

        // Reset in the middle of CALC
        write_cell(10, 1'b1); write_cell(11, 1'b1); write_cell(12, 1'b1);
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        repeat (NM / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {43'd0, rd_live, set_ready, busy, done, gen_count},
              {43'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0});
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset_busy", 64'(busy), 64'd0);
        read_board(board);
        check("midreset_board", board, 64'd0);
        model = '0;
        model[20] = 1'b1; model[21] = 1'b1; model[22] = 1'b1;
        for (int i = 20; i < 23; i++) write_cell(i, 1'b1);
        do_step(1'b0, 1'b0, 1'b0, bc, dc, mb, inj_ready);
        read_board(board);
        check("postreset_step", board, life_next(model));
        check("postreset_gen", 64'(gen_count), 64'd1);

        // Randomized boards against the model
        for (int it = 0; it < 6; it++) begin
            do_clear(1'b0, bc, dc);
            model = '0;
            gen_exp = 0;
            for (int k = 0; k < 28; k++) begin
                int   pos;
                logic val;
                pos = int'($urandom_range(0, 79));
                val = 1'($urandom_range(0, 1));
                write_cell(pos, val);
                if (pos < NM) model[pos] = val;
            end
            nsteps = int'($urandom_range(1, 3));
            for (int s = 0; s < nsteps; s++) begin
                do_step(1'b0, 1'b0, 1'b0, bc, dc, mb, inj_ready);
                model = life_next(model);
                gen_exp++;
            end
            read_board(board);
            check($sformatf("rand_board_%0d", it), board, model);
            check($sformatf("rand_gen_%0d", it), 64'(gen_count), 64'(gen_exp));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
